// File: rtl/signed_divider_module.sv
// signed_divider_module: sequential signed divider, 16-bit dividend / 8-bit divisor.
// Produces an 8-bit quotient (truncated toward zero) and an 8-bit remainder whose
// sign follows the dividend. Radix-2 restoring loop on magnitudes, one bit per clock.
// Handshake: Start_Sig level-held enable, Done_Sig one-cycle completion pulse.
// Optional build macro DIVIDER_SQ_EN exposes the internal q/r/d registers as
// debug outputs SQ_q, SQ_r, SQ_d.
module signed_divider_module (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Start_Sig,
  input  logic [15:0] Dividend,
  input  logic [7:0]  Divisor,
  output logic        Done_Sig,
  output logic [7:0]  Quotient,
  output logic [7:0]  Remainder,
  output logic        Overflow_Sig,
  output logic        DivZero_Sig
`ifdef DIVIDER_SQ_EN
  ,
  output logic [15:0] SQ_q,
  output logic [8:0]  SQ_r,
  output logic [7:0]  SQ_d
`endif
);

  typedef enum logic [3:0] {
    S_LOAD  = 4'd0,
    S_ITER  = 4'd1,
    S_FIX   = 4'd2,
    S_DONE  = 4'd3,
    S_CLEAR = 4'd4
  } step_t;

  step_t       i, i_nxt;
  logic [4:0]  x;
  logic [15:0] q;
  logic [8:0]  r;
  logic [7:0]  d;
  logic        sq, sr;

  logic [15:0] dividend_mag;
  logic [7:0]  divisor_mag;
  logic        divisor_zero;
  logic [9:0]  trial;
  logic        trial_ok;
  logic        quot_ovf;
  logic [7:0]  q_neg;
  logic [7:0]  r_neg;

  // Operand magnitudes, trial subtraction and end-of-loop sign/overflow terms.
  always_comb begin
    dividend_mag = Dividend[15] ? (~Dividend + 16'd1) : Dividend;
    divisor_mag  = Divisor[7]   ? (~Divisor  + 8'd1)  : Divisor;
    divisor_zero = (Divisor == 8'd0);
    // r[8] is always zero between iterations, so {r, q[15]} equals the 9-bit
    // shifted remainder zero-extended by one bit; bit 9 of the difference is the borrow.
    trial        = {r, q[15]} - {2'b00, d};
    trial_ok     = ~trial[9];
    quot_ovf     = sq ? (q > 16'd128) : (q > 16'd127);
    q_neg        = ~q[7:0] + 8'd1;
    r_neg        = ~r[7:0] + 8'd1;
  end

  // Step sequencing.
  always_comb begin
    i_nxt = i;
    case (i)
      S_LOAD:  i_nxt = divisor_zero ? S_DONE : S_ITER;
      S_ITER:  i_nxt = (x == 5'd16) ? S_FIX : S_ITER;
      S_FIX:   i_nxt = S_DONE;
      S_DONE:  i_nxt = S_CLEAR;
      S_CLEAR: i_nxt = S_LOAD;
      default: i_nxt = S_LOAD;
    endcase
  end

  // Step register; Start_Sig low freezes the sequence.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      i <= S_LOAD;
    else if (Start_Sig)
      i <= i_nxt;
  end

  // Datapath and registered results; frozen together with the step register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      x            <= '0;
      q            <= '0;
      r            <= '0;
      d            <= '0;
      sq           <= 1'b0;
      sr           <= 1'b0;
      Done_Sig     <= 1'b0;
      Quotient     <= '0;
      Remainder    <= '0;
      Overflow_Sig <= 1'b0;
      DivZero_Sig  <= 1'b0;
    end else if (Start_Sig) begin
      case (i)
        S_LOAD: begin
          q  <= dividend_mag;
          d  <= divisor_mag;
          r  <= '0;
          x  <= '0;
          sq <= Dividend[15] ^ Divisor[7];
          sr <= Dividend[15];
          if (divisor_zero) begin
            Quotient     <= Dividend[15] ? 8'h80 : 8'h7F;
            Remainder    <= '0;
            DivZero_Sig  <= 1'b1;
            Overflow_Sig <= 1'b0;
          end
        end
        S_ITER: begin
          if (x == 5'd16) begin
            x <= '0;
          end else begin
            if (trial_ok) begin
              r <= trial[8:0];
              q <= {q[14:0], 1'b1};
            end else begin
              r <= {r[7:0], q[15]};
              q <= {q[14:0], 1'b0};
            end
            x <= x + 5'd1;
          end
        end
        S_FIX: begin
          if (quot_ovf) begin
            Quotient     <= sq ? 8'h80 : 8'h7F;
            Remainder    <= '0;
            Overflow_Sig <= 1'b1;
          end else begin
            Quotient     <= sq ? q_neg : q[7:0];
            Remainder    <= sr ? r_neg : r[7:0];
            Overflow_Sig <= 1'b0;
          end
          DivZero_Sig <= 1'b0;
        end
        S_DONE:  Done_Sig <= 1'b1;
        S_CLEAR: Done_Sig <= 1'b0;
        default: Done_Sig <= 1'b0;
      endcase
    end
  end

`ifdef DIVIDER_SQ_EN
  assign SQ_q = q;
  assign SQ_r = r;
  assign SQ_d = d;
`endif

endmodule

// File: tb/tb_signed_divider_module.sv
// tb_signed_divider_module: directed self-checking bench for signed_divider_module.
// Expected results come from integer division in the bench and are queued when a
// division is launched, then popped and compared when Done_Sig pulses.
module tb_signed_divider_module;

  logic        CLK;
  logic        RSTn;
  logic        Start_Sig;
  logic [15:0] Dividend;
  logic [7:0]  Divisor;
  logic        Done_Sig;
  logic [7:0]  Quotient;
  logic [7:0]  Remainder;
  logic        Overflow_Sig;
  logic        DivZero_Sig;
`ifdef DIVIDER_SQ_EN
  logic [15:0] SQ_q;
  logic [8:0]  SQ_r;
  logic [7:0]  SQ_d;
`endif

  signed_divider_module dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .Start_Sig    (Start_Sig),
    .Dividend     (Dividend),
    .Divisor      (Divisor),
    .Done_Sig     (Done_Sig),
    .Quotient     (Quotient),
    .Remainder    (Remainder),
    .Overflow_Sig (Overflow_Sig),
    .DivZero_Sig  (DivZero_Sig)
`ifdef DIVIDER_SQ_EN
    ,
    .SQ_q         (SQ_q),
    .SQ_r         (SQ_r),
    .SQ_d         (SQ_d)
`endif
  );

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       ovf;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Rising-edge counter used for latency measurements.
  always @(posedge CLK) cyc <= cyc + 1;

  // Hang guard.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int   qq, rr;
    e.q = 8'h00; e.r = 8'h00; e.ovf = 1'b0; e.dz = 1'b0;
    if (b == 0) begin
      e.q  = (a < 0) ? 8'h80 : 8'h7F;
      e.dz = 1'b1;
    end else begin
      qq = a / b;
      rr = a % b;
      if (qq > 127 || qq < -128) begin
        e.ovf = 1'b1;
        e.q   = (qq < 0) ? 8'h80 : 8'h7F;
      end else begin
        e.q = qq[7:0];
        e.r = rr[7:0];
      end
    end
    return e;
  endfunction

  // Launch one division at a negedge with the block at the load step, wait for
  // Done_Sig, check latency, result and the falling edge of Done_Sig.
  task automatic run_div(input string tag, input int a, input int b, input int exp_lat,
                         input int pause_at, input int pause_len, input bit keep_start,
                         output int done_cyc);
    int   c0;
    bit   got;
    exp_t e;
    Dividend  = a[15:0];
    Divisor   = b[7:0];
    sb.push_back(model(a, b));
    Start_Sig = 1'b1;
    c0  = cyc;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        Dividend = 16'($urandom);
        Divisor  = 8'($urandom);
      end
      if (pause_len > 0 && (cyc - c0) == pause_at) begin
        Start_Sig = 1'b0;
        repeat (pause_len) @(negedge CLK);
        Start_Sig = 1'b1;
      end
      if (Done_Sig) begin
        got = 1'b1;
        break;
      end
    end
    done_cyc = cyc;
    check({tag, " done_seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(cyc - c0), 32'(exp_lat));
    e = sb.pop_front();
    check({tag, " quotient"}, 32'(Quotient), 32'(e.q));
    check({tag, " remainder"}, 32'(Remainder), 32'(e.r));
    check({tag, " overflow"}, 32'(Overflow_Sig), 32'(e.ovf));
    check({tag, " divzero"}, 32'(DivZero_Sig), 32'(e.dz));
    @(negedge CLK);
    check({tag, " done_fall"}, 32'(Done_Sig), 32'd0);
    if (!keep_start) Start_Sig = 1'b0;
  endtask

  initial begin
    int t0, t1, t2;
    RSTn      = 1'b0;
    Start_Sig = 1'b0;
    Dividend  = '0;
    Divisor   = '0;
    repeat (2) @(negedge CLK);
    check("reset outputs", 32'({Done_Sig, Quotient, Remainder, Overflow_Sig, DivZero_Sig}), 32'd0);
    RSTn = 1'b1;
    @(negedge CLK);

    run_div("100/7",       100,    7,    20, 0, 0, 1'b0, t0);
    run_div("-100/7",      -100,   7,    20, 0, 0, 1'b0, t0);
    run_div("1000/-8",     1000,   -8,   20, 0, 0, 1'b0, t0);
    run_div("16384/-128",  16384,  -128, 20, 0, 0, 1'b0, t0);
    run_div("-16384/-128", -16384, -128, 20, 0, 0, 1'b0, t0);
    run_div("32767/1",     32767,  1,    20, 0, 0, 1'b0, t0);
    run_div("-32768/127",  -32768, 127,  20, 0, 0, 1'b0, t0);
    run_div("1234/0",      1234,   0,    2,  0, 0, 1'b0, t0);
    run_div("-5/0",        -5,     0,    2,  0, 0, 1'b0, t0);

    // Freeze for 5 clocks once X has reached 7 (after edge 8).
    run_div("pause 100/7", 100,    7,    25, 8, 5, 1'b0, t0);

    // Reset in the middle of the iteration loop.
    Dividend  = 16'd100;
    Divisor   = 8'd7;
    Start_Sig = 1'b1;
    repeat (6) @(negedge CLK);
    RSTn = 1'b0;
    #1;
    check("midop reset outputs", 32'({Done_Sig, Quotient, Remainder, Overflow_Sig, DivZero_Sig}), 32'd0);
    @(negedge CLK);
    Start_Sig = 1'b0;
    RSTn      = 1'b1;
    @(negedge CLK);
    run_div("50/5",        50,     5,    20, 0, 0, 1'b0, t0);

    // Back-to-back with Start_Sig held high.
    run_div("b2b 300/-9",  300,    -9,   20, 0, 0, 1'b1, t0);
    run_div("b2b -2000/17",-2000,  17,   20, 0, 0, 1'b1, t1);
    run_div("b2b 77/-77",  77,     -77,  20, 0, 0, 1'b0, t2);
    check("b2b spacing 1-2", 32'(t1 - t0), 32'd21);
    check("b2b spacing 2-3", 32'(t2 - t1), 32'd21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
